// File: rtl/alu_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// operation encodings, slice width and the bit positions of the flag vector.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Every pipeline stage resolves one slice of this many bits
    localparam int SLICE_W = 4;

    // Flag vector layout
    localparam int FLAG_W = 4;
    localparam int CF_IDX = 0;
    localparam int OF_IDX = 1;
    localparam int ZF_IDX = 2;
    localparam int SF_IDX = 3;

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead slice. Besides the carry out it
// exposes the carry into bit 3, so the top slice can derive signed overflow.
module cla4_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               c3,
    output logic               c4
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a & b;
    assign p = a ^ b;

    // All internal carries are flattened from ci so no carry ripples
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipelined_cla_alu.sv
// Pipelined adder/subtractor: one 4-bit CLA slice per stage. Operand nibbles
// not yet consumed travel down the pipe with the beat (skew). Finished result
// nibbles accumulate alongside them (deskew), so the whole word leaves the
// last stage at once. The whole pipe freezes when the output is back-pressured.
module pipelined_cla_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             sf
);

    localparam int STAGES = WIDTH / SLICE_W;
    localparam int LAST   = STAGES - 1;

    logic              stall;
    logic [FLAG_W-1:0] flags;

    // Global stall: a held output freezes every stage, bubbles included
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : stage
        // Operand bits still unresolved when the beat reaches this stage
        localparam int REM_W = WIDTH - SLICE_W * gi;
        // Result bits known once this stage has done its slice
        localparam int RES_W = SLICE_W * (gi + 1);

        logic [REM_W-1:0]   a_in;
        logic [REM_W-1:0]   b_in;
        logic               ci_in;
        logic               op_in;
        logic               valid_in;
        logic [SLICE_W-1:0] sum_nib;
        logic               c4_w;
        logic [RES_W-1:0]   res_next;

        logic [RES_W-1:0]   res_reg;
        logic               valid_reg;
        logic               op_reg;
        logic               c4_reg;

        if (gi == 0) begin : src_port
            // SUB is data1 + ~data2 + cin; the inversion happens once, here
            assign a_in     = data1;
            assign b_in     = data2 ^ {WIDTH{op == OP_SUB}};
            assign ci_in    = cin;
            assign op_in    = op;
            assign valid_in = in_valid;
            assign res_next = sum_nib;
        end else begin : src_prev
            assign a_in     = stage[gi-1].fwd.a_reg;
            assign b_in     = stage[gi-1].fwd.b_reg;
            assign ci_in    = stage[gi-1].c4_reg;
            assign op_in    = stage[gi-1].op_reg;
            assign valid_in = stage[gi-1].valid_reg;
            assign res_next = {sum_nib, stage[gi-1].res_reg};
        end

        if (gi == LAST) begin : tail
            logic c3_w;
            logic c3_reg;

            cla4_slice u_slice (
                .a  (a_in[SLICE_W-1:0]),
                .b  (b_in[SLICE_W-1:0]),
                .ci (ci_in),
                .s  (sum_nib),
                .c3 (c3_w),
                .c4 (c4_w)
            );

            // Carry into the MSB is kept only at the top slice, for overflow
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    c3_reg <= 1'b0;
                end else if (!stall) begin
                    c3_reg <= c3_w;
                end
            end
        end else begin : mid
            cla4_slice u_slice (
                .a  (a_in[SLICE_W-1:0]),
                .b  (b_in[SLICE_W-1:0]),
                .ci (ci_in),
                .s  (sum_nib),
                .c3 (),
                .c4 (c4_w)
            );
        end

        if (gi < LAST) begin : fwd
            logic [REM_W-SLICE_W-1:0] a_reg;
            logic [REM_W-SLICE_W-1:0] b_reg;

            // Pass the unconsumed operand nibbles on, next nibble at bit 0
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (!stall) begin
                    a_reg <= a_in[REM_W-1:SLICE_W];
                    b_reg <= b_in[REM_W-1:SLICE_W];
                end
            end
        end

        // Stage register: valid bit, group carry, op and partial result
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                op_reg    <= 1'b0;
                c4_reg    <= 1'b0;
                res_reg   <= '0;
            end else if (!stall) begin
                valid_reg <= valid_in;
                op_reg    <= op_in;
                c4_reg    <= c4_w;
                res_reg   <= res_next;
            end
        end
    end

    assign out_valid = stage[LAST].valid_reg;
    assign result    = stage[LAST].res_reg;

    // Flags derive straight from the output registers; zf/sf add no cycle
    always_comb begin
        flags         = '0;
        flags[CF_IDX] = stage[LAST].c4_reg ^ (stage[LAST].op_reg == OP_SUB);
        flags[OF_IDX] = stage[LAST].tail.c3_reg ^ stage[LAST].c4_reg;
        flags[ZF_IDX] = ~|result;
        flags[SF_IDX] = result[WIDTH-1];
    end

    assign cf = flags[CF_IDX];
    assign of = flags[OF_IDX];
    assign zf = flags[ZF_IDX];
    assign sf = flags[SF_IDX];

endmodule

// File: tb/tb_pipelined_cla_alu.sv
// Bench for pipelined_cla_alu at WIDTH=16: a table of directed vectors, a
// latency probe, a random back-to-back stream, a back-pressured stream and a
// mid-flight reset. The scoreboard queue is filled at input transfers and
// drained at output transfers.
module tb_pipelined_cla_alu;
    import alu_pkg::*;

    localparam int WIDTH  = 16;
    localparam int STAGES = WIDTH / 4;
    localparam int NV     = 10;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cf;
        logic             of;
        logic             zf;
        logic             sf;
    } exp_t;

    typedef struct {
        logic             op;
        logic             cin;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        exp_t             exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op = 1'b0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] data1 = '0;
    logic [WIDTH-1:0] data2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             cf, of, zf, sf;

    int   n_vec = 0;
    int   n_err = 0;
    int   cycle = 0;
    int   beat_no = 0;
    exp_t exp_drive = '0;
    exp_t sb_q[$];
    int   pop_cycles[$];
    logic prev_stall = 1'b0;
    exp_t held = '0;
    logic toggle_en = 1'b0;
    int   tog_cnt = 0;
    vec_t tbl [NV];

    pipelined_cla_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cin       (cin),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cf        (cf),
        .of        (of),
        .zf        (zf),
        .sf        (sf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Downstream readiness: 1 normally, toggling every 2 cycles when enabled
    always @(posedge clk) begin
        #1;
        if (toggle_en) begin
            tog_cnt   = tog_cnt + 1;
            out_ready = tog_cnt[1];
        end else begin
            out_ready = 1'b1;
        end
    end

    function automatic exp_t model(input logic o, input logic c,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   sum;
        exp_t             e;
        bb    = o ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        e.res = sum[WIDTH-1:0];
        e.cf  = o ? ~sum[WIDTH] : sum[WIDTH];
        e.of  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        e.zf  = (sum[WIDTH-1:0] == '0);
        e.sf  = sum[WIDTH-1];
        return e;
    endfunction

    function automatic vec_t mk(input logic o, input logic c,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] r, input logic f_cf,
                                input logic f_of, input logic f_zf, input logic f_sf);
        vec_t v;
        v.op  = o;
        v.cin = c;
        v.d1  = a;
        v.d2  = b;
        v.exp = '{res: r, cf: f_cf, of: f_of, zf: f_zf, sf: f_sf};
        return v;
    endfunction

    // Output-side scoreboard, handshake and stability checks, once per cycle
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = '{res: result, cf: cf, of: of, zf: zf, sf: sf};
        if (!rst_n) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            n_vec++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_err++;
                $display("FAIL in_ready: got %b, expected %b (out_valid=%b out_ready=%b)",
                         in_ready, !(out_valid && !out_ready), out_valid, out_ready);
            end
            if (prev_stall) begin
                n_vec++;
                if (got !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got res=%h flags=%b%b%b%b, expected res=%h flags=%b%b%b%b",
                             got.res, got.cf, got.of, got.zf, got.sf,
                             held.res, held.cf, held.of, held.zf, held.sf);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got res=%h, expected no output", got.res);
                end else begin
                    e = sb_q.pop_front();
                    pop_cycles.push_back(cycle);
                    beat_no++;
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL beat %0d: got res=%h cf=%b of=%b zf=%b sf=%b, expected res=%h cf=%b of=%b zf=%b sf=%b",
                                 beat_no, got.res, got.cf, got.of, got.zf, got.sf,
                                 e.res, e.cf, e.of, e.zf, e.sf);
                    end else begin
                        $display("beat %0d: res=%h cf=%b of=%b zf=%b sf=%b ok",
                                 beat_no, got.res, got.cf, got.of, got.zf, got.sf);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_drive);
            prev_stall = out_valid && !out_ready;
            held       = got;
        end
    end

    // Offer one beat (called just after a rising edge) and hold it until taken
    task automatic send(input logic o, input logic c,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input exp_t e);
        logic taken;
        taken     = 1'b0;
        in_valid  = 1'b1;
        op        = o;
        cin       = c;
        data1     = a;
        data2     = b;
        exp_drive = e;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic             o;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        o = 1'($urandom_range(0, 1));
        c = o ? 1'b1 : 1'($urandom_range(0, 1));
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        send(o, c, a, b, model(o, c, a, b));
    endtask

    initial begin
        int lat;

        tbl[0] = mk(OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[1] = mk(OP_SUB, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[2] = mk(OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[3] = mk(OP_ADD, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(OP_SUB, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5] = mk(OP_SUB, 1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[6] = mk(OP_SUB, 1'b0, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(OP_ADD, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8] = mk(OP_ADD, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[9] = mk(OP_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset and check the idle output state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || result !== '0 || cf !== 1'b0 || of !== 1'b0
            || sf !== 1'b0 || zf !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got v=%b res=%h cf=%b of=%b zf=%b sf=%b rdy=%b, expected v=0 res=0000 cf=0 of=0 zf=1 sf=0 rdy=1",
                     out_valid, result, cf, of, zf, sf, in_ready);
        end
        @(posedge clk);
        #1;

        // Directed vectors, issued back to back
        for (int i = 0; i < NV; i++)
            send(tbl[i].op, tbl[i].cin, tbl[i].d1, tbl[i].d2, tbl[i].exp);
        drain();

        // Latency of a lone beat into an empty pipe
        in_valid  = 1'b1;
        op        = OP_ADD;
        cin       = 1'b0;
        data1     = 16'h0F0F;
        data2     = 16'h00F1;
        exp_drive = model(OP_ADD, 1'b0, 16'h0F0F, 16'h00F1);
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        n_vec++;
        if (lat != STAGES) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, expected %0d", lat, STAGES);
        end
        @(posedge clk);
        #1;
        drain();

        // Eight random beats with out_ready held high: results must be gapless
        pop_cycles.delete();
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        n_vec++;
        if (pop_cycles.size() != 8) begin
            n_err++;
            $display("FAIL stream_count: got %0d results, expected 8", pop_cycles.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                n_vec++;
                if (pop_cycles[i] - pop_cycles[i-1] != 1) begin
                    n_err++;
                    $display("FAIL stream_gap: got spacing %0d before result %0d, expected 1",
                             pop_cycles[i] - pop_cycles[i-1], i);
                end
            end
        end

        // Back-pressured stream: out_ready toggles every 2 cycles
        toggle_en = 1'b1;
        for (int i = 0; i < 12; i++) send_rand();
        drain();
        toggle_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three beats in flight: nothing may emerge afterwards
        send(OP_ADD, 1'b0, 16'h1111, 16'h2222, model(OP_ADD, 1'b0, 16'h1111, 16'h2222));
        send(OP_SUB, 1'b1, 16'h3333, 16'h1111, model(OP_SUB, 1'b1, 16'h3333, 16'h1111));
        send(OP_ADD, 1'b1, 16'hABCD, 16'h1234, model(OP_ADD, 1'b1, 16'hABCD, 16'h1234));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_valid: got out_valid=%b at cycle %0d after reset, expected 0",
                         out_valid, i + 1);
            end
        end
        @(posedge clk);
        #1;
        send(OP_SUB, 1'b1, 16'h1000, 16'h0001, model(OP_SUB, 1'b1, 16'h1000, 16'h0001));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_cla_alu.md
# pipelined_cla_alu

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA slices, one slice per pipeline stage, with a valid/ready handshake on both sides. It is the wide-operand successor to the 4-bit combinational adder. It sits between the operand register file and the result writeback logic. It adds subtraction, carry-in, zero/sign flags and full throughput of one operation per cycle at any width that is a multiple of 4.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4, range 4..64
- STAGES, derived = WIDTH/4, pipeline depth (not user-settable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block can accept a beat this cycle
- op  in  1  0 = ADD, 1 = SUB (Data1 − Data2)
- cin  in  1  carry-in; for SUB, acts as inverted borrow-in (1 = no borrow)
- data1  in  WIDTH  operand A
- data2  in  WIDTH  operand B
- out_valid  out  1  result beat available
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  sum/difference
- cf  out  1  carry flag (ADD: carry-out; SUB: borrow = NOT carry-out)
- of  out  1  signed overflow = carry into MSB XOR carry out of MSB
- zf  out  1  result == 0
- sf  out  1  result[WIDTH-1]

## Operation
- SUB is implemented as data1 + ~data2 + cin. The caller drives cin = 1 for a plain subtract.
- Stage k (k = 0..STAGES-1) computes bits [4k+3:4k] with one 4-bit CLA slice. Its inputs are the registered group carry from stage k-1 (cin at stage 0) and operand nibble k, already XOR-inverted for SUB.
- Operands are skewed. Stage k consumes nibble k, which was carried unchanged through k registers. Finished result nibbles are deskewed so all WIDTH bits emerge in the same cycle.
- The slice exports c3 (carry into nibble bit 3) and c4 (carry out).
- The final stage registers c4 and c3 of the top slice for cf/of.
- zf is the NOR of the assembled result, computed in the output register stage from the registered nibbles. It adds no extra cycle: it is combinational on the output register.
- Handshake is a global-stall pipeline:
  - stall = out_valid && !out_ready
  - in_ready = !stall
  - All stage registers and valid bits hold while stall is 1.
- A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Bubbles (in_valid = 0) propagate as valid = 0 slots. There is no compaction.
- There is no state machine beyond the per-stage valid shift register.

## Timing
- Latency: STAGES cycles from the input transfer edge to out_valid high (16-bit: 4 cycles).
- Throughput: 1 beat/cycle when out_ready is held at 1.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- Reset (rst_n = 0 at a clk edge):
  - All valid bits clear.
  - result, cf, of and sf read 0. zf reads 1 (result 0), but it is masked by out_valid = 0.
  - in_ready is 1 the cycle after reset.
- Reset mid-operation discards every in-flight beat. No partial result is emitted.
- Stall with a bubble in front: registers still hold. Bubbles are not squeezed out.
- Simultaneous output transfer and input transfer in the same cycle is legal. The pipeline advances by one.
- Output stability: result and flags must not change while out_valid && !out_ready.
- WIDTH = 4 degenerates to one stage with latency 1. It is functionally equivalent to the 4-bit adder plus the new flags.

## Structure
- Package alu_pkg holds:
  - localparam OP_ADD = 1'b0, OP_SUB = 1'b1
  - localparam SLICE_W = 4
  - the flag-vector index constants CF_IDX/OF_IDX/ZF_IDX/SF_IDX
- Sub-module cla4_slice is a pure combinational 4-bit generate/propagate adder.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], c3, c4.
  - It is instantiated STAGES times in a generate loop.
- The top module holds the operand skew registers, result deskew registers, valid shift register and stall logic.

## Test plan
- WIDTH=16, ADD 0x7FFF + 0x0001, cin=0 → after 4 cycles result=0x8000, cf=0, of=1, sf=1, zf=0.
- WIDTH=16, SUB 0x0000 − 0x0001, cin=1 → result=0xFFFF, cf=1 (borrow), of=0, sf=1.
- WIDTH=16, ADD 0xFFFF + 0x0001 → result=0x0000, cf=1, zf=1, of=0. This checks carry propagating through all 4 stages.
- Back-to-back stream of 8 random ADD/SUB beats with out_ready=1 → 8 consecutive results, in order, each matching the reference model, with no gaps.
- Stream with out_ready toggled 1/0 every 2 cycles → in_ready = !(out_valid && !out_ready), no beat lost or duplicated, and result stable during the stall.
- rst_n pulled low for 1 cycle while 3 beats are in flight → out_valid stays 0 for the following STAGES cycles, and a new beat issued after reset emerges correctly.
